// File: rtl/cache_mem_arbiter.sv
// Two-requester arbiter sharing one cache-to-memory port.
// Requests are granted round-robin onto the memory request channel. The ID of
// each issued request goes into an in-order tag FIFO, and the FIFO head steers
// each memory response back to the requester that issued it.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   req{0,1}_val/rdy/msg    cache request channels (77-bit mem_req_4B_t)
//   resp{0,1}_val/rdy/msg   cache response channels (47-bit mem_resp_4B_t)
//   mem_req_val/rdy/msg     shared memory request channel
//   mem_resp_val/rdy/msg    shared memory response channel
//   outstanding             number of requests in flight
//   proto_err               sticky flag: response arrived with nothing in flight
module cache_mem_arbiter #(
   parameter int unsigned NUM_OUTSTANDING = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              req0_val,
   output logic                              req0_rdy,
   input  logic [76:0]                       req0_msg,
   output logic                              resp0_val,
   input  logic                              resp0_rdy,
   output logic [46:0]                       resp0_msg,
   input  logic                              req1_val,
   output logic                              req1_rdy,
   input  logic [76:0]                       req1_msg,
   output logic                              resp1_val,
   input  logic                              resp1_rdy,
   output logic [46:0]                       resp1_msg,
   output logic                              mem_req_val,
   input  logic                              mem_req_rdy,
   output logic [76:0]                       mem_req_msg,
   input  logic                              mem_resp_val,
   output logic                              mem_resp_rdy,
   input  logic [46:0]                       mem_resp_msg,
   output logic [$clog2(NUM_OUTSTANDING):0]  outstanding,
   output logic                              proto_err
);

   localparam int unsigned PtrW = $clog2(NUM_OUTSTANDING);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CountFull = CntW'(NUM_OUTSTANDING);

   logic                       prio_q;
   logic [NUM_OUTSTANDING-1:0] tags_q;
   logic [PtrW-1:0]            head_q;
   logic [PtrW-1:0]            tail_q;
   logic [CntW-1:0]            count_q;
   logic                       proto_err_q;

   logic full;
   logic empty;
   logic gnt;
   logic push;
   logic pop;
   logic head_id;
   logic head_rdy;

   always_comb begin
      full  = (count_q == CountFull);
      empty = (count_q == '0);

      // Prio only moves on a handshake, so the grant is stable across stalls.
      gnt = (req0_val & req1_val) ? prio_q : req1_val;

      // Gating with reset drops every val/rdy output as soon as reset asserts.
      mem_req_val = reset & (req0_val | req1_val) & ~full;
      mem_req_msg = gnt ? req1_msg : req0_msg;
      req0_rdy    = mem_req_val & ~gnt & mem_req_rdy;
      req1_rdy    = mem_req_val & gnt & mem_req_rdy;
      push        = mem_req_val & mem_req_rdy;

      head_id      = tags_q[head_q];
      head_rdy     = head_id ? resp1_rdy : resp0_rdy;
      resp0_val    = reset & mem_resp_val & ~empty & ~head_id;
      resp1_val    = reset & mem_resp_val & ~empty & head_id;
      resp0_msg    = mem_resp_msg;
      resp1_msg    = mem_resp_msg;
      mem_resp_rdy = reset & ~empty & head_rdy;
      pop          = mem_resp_val & mem_resp_rdy;

      outstanding = count_q;
      proto_err   = proto_err_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio_q      <= 1'b0;
         tags_q      <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         if (push) begin
            tags_q[tail_q] <= gnt;
            tail_q         <= tail_q + PtrW'(1);
            prio_q         <= ~gnt;
         end
         if (pop) begin
            head_q <= head_q + PtrW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntW'(1);
         end
         if (mem_resp_val && empty) begin
            proto_err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: a grant table, then scoreboarded traffic with a
// behavioural memory and two requesters, plus hand-written corner sequences.
module tb_cache_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_val = 1'b0, req1_val = 1'b0;
   logic        req0_rdy, req1_rdy;
   logic [76:0] req0_msg = '0, req1_msg = '0;
   logic        resp0_val, resp1_val;
   logic        resp0_rdy = 1'b0, resp1_rdy = 1'b0;
   logic [46:0] resp0_msg, resp1_msg;
   logic        mem_req_val;
   logic        mem_req_rdy = 1'b1;
   logic [76:0] mem_req_msg;
   logic        mem_resp_val = 1'b0;
   logic        mem_resp_rdy;
   logic [46:0] mem_resp_msg = '0;
   logic [2:0]  outstanding;
   logic        proto_err;

   cache_mem_arbiter #(.NUM_OUTSTANDING(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_val     (req0_val),
      .req0_rdy     (req0_rdy),
      .req0_msg     (req0_msg),
      .resp0_val    (resp0_val),
      .resp0_rdy    (resp0_rdy),
      .resp0_msg    (resp0_msg),
      .req1_val     (req1_val),
      .req1_rdy     (req1_rdy),
      .req1_msg     (req1_msg),
      .resp1_val    (resp1_val),
      .resp1_rdy    (resp1_rdy),
      .resp1_msg    (resp1_msg),
      .mem_req_val  (mem_req_val),
      .mem_req_rdy  (mem_req_rdy),
      .mem_req_msg  (mem_req_msg),
      .mem_resp_val (mem_resp_val),
      .mem_resp_rdy (mem_resp_rdy),
      .mem_resp_msg (mem_resp_msg),
      .outstanding  (outstanding),
      .proto_err    (proto_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int failed = 0;

   // Environment state.
   logic [31:0] src0_q[$], src1_q[$];
   logic [46:0] exp0_q[$], exp1_q[$], mem_q[$];
   bit          gnt_log[$], deliv_log[$];
   bit          en0 = 0, en1 = 0, mem_en = 0, rdy0 = 1, rdy1 = 1;
   bit          saw_resp1 = 0;
   int          max_out = 0, n_resp0 = 0, n_resp1 = 0;

   // Values sampled in the last cycle() before its clock edge.
   logic s_mval, s_r0rdy, s_r1rdy, s_hm, s_hr, s_mresp_rdy, s_resp0v, s_resp1v, s_perr;
   logic [2:0] s_out;

   typedef struct {
      logic r0v, r1v, mrdy;
      logic mval, r0rdy, r1rdy;
      logic chk_sel, sel;
      logic [2:0] cnt;
   } vec_t;
   vec_t vecs[10];

   task automatic chk1(input logic act, input logic exp, input string name);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chkw(input logic [76:0] act, input logic [76:0] exp, input string name);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] data_of(input logic [31:0] addr);
      return ((addr - 32'h1000) >> 2) + 32'hA;
   endfunction

   // Opaque field carries the requester ID in its MSB.
   function automatic logic [76:0] mk_req(input logic id, input logic [31:0] addr);
      return {3'd0, id, addr[8:2], addr, 2'd0, 32'd0};
   endfunction

   function automatic logic [46:0] resp_of(input logic [76:0] r);
      return {r[76:74], r[73:66], 2'b00, r[33:32], data_of(r[65:34])};
   endfunction

   task automatic drive();
      req0_val = en0 && (src0_q.size() > 0);
      req0_msg = '0;
      if (src0_q.size() > 0) req0_msg = mk_req(1'b0, src0_q[0]);
      req1_val = en1 && (src1_q.size() > 0);
      req1_msg = '0;
      if (src1_q.size() > 0) req1_msg = mk_req(1'b1, src1_q[0]);
      mem_resp_val = mem_en && (mem_q.size() > 0);
      mem_resp_msg = '0;
      if (mem_q.size() > 0) mem_resp_msg = mem_q[0];
      resp0_rdy = rdy0;
      resp1_rdy = rdy1;
   endtask

   // One clock: drive at negedge, sample/score 1 time unit later, update models after posedge.
   task automatic cycle();
      logic h0, h1, o0, o1;
      logic [76:0] fwd;
      logic [46:0] e;
      drive();
      #1;
      s_hm = mem_req_val && mem_req_rdy;
      s_hr = mem_resp_val && mem_resp_rdy;
      h0 = req0_val && req0_rdy;
      h1 = req1_val && req1_rdy;
      o0 = resp0_val && resp0_rdy;
      o1 = resp1_val && resp1_rdy;
      s_mval = mem_req_val; s_r0rdy = req0_rdy; s_r1rdy = req1_rdy;
      s_mresp_rdy = mem_resp_rdy; s_resp0v = resp0_val; s_resp1v = resp1_val;
      s_perr = proto_err; s_out = outstanding;
      fwd = mem_req_msg;
      if (resp1_val) saw_resp1 = 1;
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      if (s_hm) begin
         chk1(h0 ^ h1, 1'b1, "gnt_onehot");
         chkw(fwd, h1 ? req1_msg : req0_msg, "req_msg_fwd");
         gnt_log.push_back(h1);
      end
      if (o0) begin
         deliv_log.push_back(1'b0);
         n_resp0++;
         if (exp0_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL resp0_unexpected: got %0h expected none", resp0_msg);
         end else begin
            e = exp0_q.pop_front();
            chkw(77'(resp0_msg), 77'(e), "resp0_msg");
         end
      end
      if (o1) begin
         deliv_log.push_back(1'b1);
         n_resp1++;
         if (exp1_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL resp1_unexpected: got %0h expected none", resp1_msg);
         end else begin
            e = exp1_q.pop_front();
            chkw(77'(resp1_msg), 77'(e), "resp1_msg");
         end
      end
      @(posedge clk);
      if (h0) begin exp0_q.push_back(resp_of(req0_msg)); void'(src0_q.pop_front()); end
      if (h1) begin exp1_q.push_back(resp_of(req1_msg)); void'(src1_q.pop_front()); end
      if (s_hr) void'(mem_q.pop_front());
      if (s_hm) mem_q.push_back(resp_of(fwd));
      @(negedge clk);
   endtask

   function automatic bit idle();
      return src0_q.size() == 0 && src1_q.size() == 0 && exp0_q.size() == 0 &&
             exp1_q.size() == 0 && mem_q.size() == 0;
   endfunction

   task automatic run_until_idle(input int budget, input string name);
      for (int i = 0; i < budget && !idle(); i++) cycle();
      chk1(idle(), 1'b1, name);
   endtask

   task automatic chk_quiet(input string tag);
      chk1(mem_req_val, 1'b0, {tag, "_mem_req_val"});
      chk1(req0_rdy, 1'b0, {tag, "_req0_rdy"});
      chk1(req1_rdy, 1'b0, {tag, "_req1_rdy"});
      chk1(resp0_val, 1'b0, {tag, "_resp0_val"});
      chk1(resp1_val, 1'b0, {tag, "_resp1_val"});
      chk1(mem_resp_rdy, 1'b0, {tag, "_mem_resp_rdy"});
      chkw(77'(outstanding), 77'(0), {tag, "_outstanding"});
      chk1(proto_err, 1'b0, {tag, "_proto_err"});
   endtask

   // Asserts reset, checks the outputs while it is low, releases at a negedge.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      chk_quiet(tag);
      src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete(); mem_q.delete();
      gnt_log.delete(); deliv_log.delete();
      en0 = 0; en1 = 0; mem_en = 0; rdy0 = 1; rdy1 = 1;
      saw_resp1 = 0; max_out = 0; n_resp0 = 0; n_resp1 = 0;
      mem_req_rdy = 1'b1;
      drive();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      // Grant table from reset state; rows run back to back, so prio and count carry over.
      //          r0v r1v mrdy  mval r0r r1r  chk sel  cnt
      vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2};
      vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3};
      vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4};

      #1;
      do_reset("rst0");

      for (int i = 0; i < 10; i++) begin
         req0_val = vecs[i].r0v;
         req1_val = vecs[i].r1v;
         mem_req_rdy = vecs[i].mrdy;
         req0_msg = mk_req(1'b0, 32'h3000 + 32'(i * 4));
         req1_msg = mk_req(1'b1, 32'h4000 + 32'(i * 4));
         #1;
         chk1(mem_req_val, vecs[i].mval, $sformatf("tbl%0d_mem_req_val", i));
         chk1(req0_rdy, vecs[i].r0rdy, $sformatf("tbl%0d_req0_rdy", i));
         chk1(req1_rdy, vecs[i].r1rdy, $sformatf("tbl%0d_req1_rdy", i));
         chkw(77'(outstanding), 77'(vecs[i].cnt), $sformatf("tbl%0d_outstanding", i));
         if (vecs[i].chk_sel)
            chkw(mem_req_msg, vecs[i].sel ? req1_msg : req0_msg, $sformatf("tbl%0d_msg", i));
         @(posedge clk);
         @(negedge clk);
      end

      // Single requester, three back-to-back reads, then memory answers A, B, C.
      do_reset("rst1");
      src0_q = '{32'h1000, 32'h1004, 32'h1008};
      en0 = 1;
      for (int i = 0; i < 3; i++) cycle();
      chkw(77'(gnt_log.size()), 77'(3), "t1_issue_3_in_3");
      mem_en = 1;
      run_until_idle(20, "t1_drain");
      chkw(77'(max_out), 77'(3), "t1_peak_outstanding");
      chkw(77'(n_resp0), 77'(3), "t1_resp0_count");
      chk1(saw_resp1, 1'b0, "t1_no_resp1");

      // Both requesters continuously valid, zero-latency memory.
      do_reset("rst2");
      for (int i = 0; i < 4; i++) begin
         src0_q.push_back(32'h1100 + 32'(i * 4));
         src1_q.push_back(32'h2000 + 32'(i * 4));
      end
      en0 = 1; en1 = 1; mem_en = 1;
      run_until_idle(40, "t2_drain");
      chkw(77'(gnt_log.size()), 77'(8), "t2_grant_count");
      for (int i = 0; i < 8 && i < gnt_log.size(); i++)
         chk1(gnt_log[i], 1'(i % 2), $sformatf("t2_grant%0d", i));
      chkw(77'(n_resp0), 77'(4), "t2_resp0_count");
      chkw(77'(n_resp1), 77'(4), "t2_resp1_count");

      // Fill the tag FIFO with responses held back, then release one.
      do_reset("rst3");
      for (int i = 0; i < 6; i++) src0_q.push_back(32'h1200 + 32'(i * 4));
      src1_q = '{32'h2200, 32'h2204};
      en0 = 1; en1 = 1; mem_en = 1; rdy0 = 0; rdy1 = 0;
      for (int i = 0; i < 4; i++) cycle();
      chkw(77'(gnt_log.size()), 77'(4), "t3_four_issued");
      cycle();
      chk1(s_mval, 1'b0, "t3_full_mem_req_val");
      chk1(s_r0rdy, 1'b0, "t3_full_req0_rdy");
      chk1(s_r1rdy, 1'b0, "t3_full_req1_rdy");
      chkw(77'(s_out), 77'(4), "t3_full_outstanding");
      rdy0 = 1; rdy1 = 1;
      cycle();
      chk1(s_hr, 1'b1, "t3_pop_when_full");
      chk1(s_mval, 1'b0, "t3_push_blocked_on_pop");
      cycle();
      chk1(s_hm, 1'b1, "t3_issue_after_pop");
      run_until_idle(40, "t3_drain");
      chk1(max_out <= 4, 1'b1, "t3_max_outstanding");

      // Head response for requester 1 stalls; requester 0's response waits behind it.
      do_reset("rst4");
      src1_q = '{32'h2300};
      en1 = 1;
      cycle();
      src0_q = '{32'h1300};
      en0 = 1;
      cycle();
      mem_en = 1; rdy1 = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk1(s_mresp_rdy, 1'b0, $sformatf("t4_stall%0d_mem_resp_rdy", i));
         chk1(s_resp1v, 1'b1, $sformatf("t4_stall%0d_resp1_val", i));
         chk1(s_resp0v, 1'b0, $sformatf("t4_stall%0d_resp0_val", i));
      end
      rdy1 = 1;
      run_until_idle(20, "t4_drain");
      chkw(77'(deliv_log.size()), 77'(2), "t4_deliveries");
      if (deliv_log.size() == 2) begin
         chk1(deliv_log[0], 1'b1, "t4_first_to_1");
         chk1(deliv_log[1], 1'b0, "t4_second_to_0");
      end

      // Response with nothing in flight.
      do_reset("rst5");
      mem_en = 1;
      mem_q.push_back(47'h0_1234);
      cycle();
      chk1(s_mresp_rdy, 1'b0, "t5_mem_resp_rdy");
      chk1(s_resp0v, 1'b0, "t5_resp0_val");
      chk1(s_resp1v, 1'b0, "t5_resp1_val");
      chk1(s_perr, 1'b0, "t5_perr_before_edge");
      mem_q.delete();
      mem_en = 0;
      cycle();
      chk1(s_perr, 1'b1, "t5_perr_set");
      for (int i = 0; i < 3; i++) cycle();
      chk1(s_perr, 1'b1, "t5_perr_sticky");

      // Asynchronous reset mid-burst with two requests in flight.
      do_reset("rst6");
      src0_q = '{32'h1400, 32'h1404, 32'h1408};
      src1_q = '{32'h2400, 32'h2404, 32'h2408};
      en0 = 1; en1 = 1;
      cycle();
      cycle();
      #1;
      chkw(77'(outstanding), 77'(2), "t6_two_outstanding");
      mem_en = 1;
      drive();
      #1;
      do_reset("t6_async");
      src0_q = '{32'h1500};
      src1_q = '{32'h2500};
      en0 = 1; en1 = 1; mem_en = 1;
      run_until_idle(20, "t6_drain");
      chkw(77'(gnt_log.size()), 77'(2), "t6_grant_count");
      if (gnt_log.size() == 2) begin
         chk1(gnt_log[0], 1'b0, "t6_first_grant_0");
         chk1(gnt_log[1], 1'b1, "t6_second_grant_1");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Two-requester memory-port arbiter that shares one cache-to-memory port between two cache instances, e.g. instruction and data caches.
- Grants single-word requests round-robin onto the shared memory request channel.
- Records the requester ID of every issued request in an in-order tag FIFO.
- Steers each memory response back to the requester that issued it.
- Sits between the caches' cache_req/cache_resp ports and the test memory or main memory.

Parameters:
- NUM_OUTSTANDING, default 4: tag FIFO depth and the maximum number of in-flight memory requests. Power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req0_val  in  1  requester 0 request valid
- req0_rdy  out  1  requester 0 request ready
- req0_msg  in  77  requester 0 request, mem_req_4B_t
- resp0_val  out  1  response valid to requester 0
- resp0_rdy  in  1  requester 0 response ready
- resp0_msg  out  47  response to requester 0, mem_resp_4B_t
- req1_val, req1_rdy, req1_msg, resp1_val, resp1_rdy, resp1_msg: same as requester 0, for requester 1
- mem_req_val  out  1  shared memory request valid
- mem_req_rdy  in  1  memory request ready
- mem_req_msg  out  77  mem_req_4B_t forwarded unmodified
- mem_resp_val  in  1  memory response valid
- mem_resp_rdy  out  1  memory response ready
- mem_resp_msg  in  47  mem_resp_4B_t
- outstanding  out  $clog2(NUM_OUTSTANDING)+1  in-flight request count
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Handshakes are val/rdy. A transfer occurs in a cycle where val and rdy are both high at the rising clk edge.
- No val output may combinationally depend on the matching rdy input.
- State:
  - prio: 1-bit round-robin pointer, naming the preferred requester.
  - Tag FIFO: NUM_OUTSTANDING x 1 bit, with head/tail pointers that wrap modulo NUM_OUTSTANDING.
  - count: occupancy register.
  - proto_err: sticky flag.
- Reset (reset low, asynchronous): prio=0, head=tail=0, count=0, proto_err=0.
  - All val/rdy outputs are 0 while reset is low; message outputs are don't-care.
  - In-flight responses are discarded. The memory side must be reset together with this block.
- Request path (combinational grant, zero latency):
  - full = (count == NUM_OUTSTANDING).
  - If full: mem_req_val=0 and req0_rdy=req1_rdy=0.
  - Otherwise, grant the valid requester when exactly one is valid. When both are valid, grant the requester named by prio.
  - mem_req_val equals req0_val OR req1_val; mem_req_msg is the granted requester's msg.
  - Only the granted requester sees reqX_rdy = mem_req_rdy. The other requester sees rdy=0.
  - On the mem_req handshake: push the granted ID at tail, tail++, and set prio = NOT granted ID.
  - prio is unchanged in cycles without a request handshake.
  - A granted requester keeps the grant while mem_req_rdy=0 only if prio is unchanged. Because prio updates only on handshake, the grant is stable across stalls.
- Response path (combinational steering, zero latency):
  - empty = (count == 0). The head ID selects the destination.
  - respX_val = mem_resp_val AND NOT empty AND (head==X); respX_msg = mem_resp_msg. The non-selected resp val is 0.
  - mem_resp_rdy = NOT empty AND resp[head]_rdy.
  - On the mem_resp handshake: head++.
- Count update:
  - count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - A push is blocked whenever full, even if a pop occurs in the same cycle. This avoids a rdy-to-rdy combinational path.
  - A pop when full is legal.
- Error handling:
  - mem_resp_val=1 while empty: mem_resp_rdy=0, no pop, proto_err set to 1 and held until reset.
- Ordering: memory returns responses in request order. Response opaque and type fields pass through untouched.
- Pointer wrap: head and tail wrap from NUM_OUTSTANDING-1 to 0.
- outstanding = count.

Test Plan:
1. Only req0 valid, 3 back-to-back reads (addr 0x1000/0x1004/0x1008), memory responds data 0xA/0xB/0xC -> 3 mem_req handshakes in 3 cycles; resp0 gets A, B, C in order; resp1_val never 1; outstanding peaks at 3.
2. Both requesters continuously valid for 8 requests with zero-latency memory -> grants alternate 0,1,0,1,...; each requester gets 4 requests and its own 4 responses, matched by address-tagged data.
3. mem_resp_rdy held back so NUM_OUTSTANDING=4 requests are issued -> 5th cycle has req0_rdy=req1_rdy=0 and mem_req_val=0; after one response pop, the next request issues the following cycle; outstanding never exceeds 4.
4. Head response destined for requester 1 with resp1_rdy=0 for 5 cycles, requester 0 response queued behind it -> mem_resp_rdy=0 for 5 cycles, no reordering; delivery order is 1 then 0.
5. mem_resp_val=1 after reset with nothing issued -> mem_resp_rdy=0, proto_err=1 next cycle and it stays 1; resp0_val=resp1_val=0.
6. reset asserted low mid-burst with 2 outstanding -> all rdy/val outputs drop immediately (asynchronously); after release outstanding=0, prio=0, and the first simultaneous requests grant requester 0.
